// File: rtl/regfile_dump_if.sv
// -----------------------------------------------------------------------------
// regfile_dump_if
// Bundles the two buses of the dump sequencer:
//   - debug read port of the register file (rd_addr out, rd_data in)
//   - valid/ready byte stream towards the serial transmitter / byte display
// Modports:
//   master : the dump sequencer (drives rd_addr, tx_data, tx_valid)
//   slave  : register file + byte consumer (drives rd_data, tx_ready)
// -----------------------------------------------------------------------------
interface regfile_dump_if;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output rd_addr,
    input  rd_data,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// -----------------------------------------------------------------------------
// regfile_dump
// Debug readout sequencer. On i_start it walks registers FIRST_REG..LAST_REG
// through the register file's debug read port, snapshots each register in its
// LOAD cycle and streams it out as bytes: optional index tag, then data MSB
// first. The block never writes the register file.
// Ports:
//   i_clk   : clock, all state on posedge
//   i_rst   : synchronous active-high reset
//   i_start : one-cycle dump request, honoured only while idle
//   bus     : regfile_dump_if.master (rd_addr/rd_data, tx_data/tx_valid/tx_ready)
//   o_busy  : high whenever the sequencer is not idle
//   o_done  : one-cycle pulse after the last byte of a dump is accepted
// -----------------------------------------------------------------------------
module regfile_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int TAG_EN    = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  regfile_dump_if.master bus,
  output logic           o_busy,
  output logic           o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);
  // Index of the final byte of one register's record.
  localparam logic [2:0] LAST_CNT  = (TAG_EN != 0) ? 3'd4 : 3'd3;

  // Byte position 0 is the tag, 1..4 are data bytes MSB..LSB; without the
  // tag the counter is shifted up by one so that byte 0 lands on the MSB.
  function automatic logic [7:0] sel_byte(input logic [31:0] snap,
                                          input logic [2:0]  cnt,
                                          input logic [4:0]  idx);
    logic [2:0] pos;
    pos = (TAG_EN != 0) ? cnt : (cnt + 3'd1);
    case (pos)
      3'd0:    sel_byte = {3'b000, idx};
      3'd1:    sel_byte = snap[31:24];
      3'd2:    sel_byte = snap[23:16];
      3'd3:    sel_byte = snap[15:8];
      3'd4:    sel_byte = snap[7:0];
      default: sel_byte = 8'h00;
    endcase
  endfunction

  state_t      r_state;
  logic [4:0]  r_reg_idx;
  logic [2:0]  r_byte_cnt;
  logic [31:0] r_snap;
  logic [4:0]  r_rd_addr;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_busy;
  logic        r_done;

  state_t      w_nxt_state;
  logic [4:0]  w_nxt_reg_idx;
  logic [2:0]  w_nxt_byte_cnt;
  logic [31:0] w_nxt_snap;
  logic [7:0]  w_nxt_tx_data;
  logic        w_hs;
  logic        w_last_byte;

  // r_tx_valid is high exactly in SEND, so it doubles as the state qualifier.
  assign w_hs        = r_tx_valid && bus.tx_ready;
  assign w_last_byte = (r_byte_cnt == LAST_CNT);

  // Next-state and next-datapath logic of the dump sequencer.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_reg_idx  = r_reg_idx;
    w_nxt_byte_cnt = r_byte_cnt;
    w_nxt_snap     = r_snap;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_nxt_reg_idx = FIRST_IDX;
          w_nxt_state   = ST_LOAD;
        end else begin
          w_nxt_state   = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // rd_addr already equals reg_idx here, so rd_data is this register.
        w_nxt_snap     = bus.rd_data;
        w_nxt_byte_cnt = 3'd0;
        w_nxt_state    = ST_SEND;
      end
      ST_SEND: begin
        if (w_hs) begin
          if (!w_last_byte) begin
            w_nxt_byte_cnt = r_byte_cnt + 3'd1;
          end else if (r_reg_idx == LAST_IDX) begin
            w_nxt_state    = ST_DONE;
          end else begin
            w_nxt_reg_idx  = r_reg_idx + 5'd1;
            w_nxt_state    = ST_LOAD;
          end
        end else begin
          w_nxt_state = ST_SEND;
        end
      end
      ST_DONE: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // Output byte computed from next-cycle values so tx_data can be registered;
  // it only changes on a handshake, which keeps it stable while stalled.
  always_comb begin
    if (w_nxt_state == ST_SEND) begin
      w_nxt_tx_data = sel_byte(w_nxt_snap, w_nxt_byte_cnt, w_nxt_reg_idx);
    end else begin
      w_nxt_tx_data = 8'h00;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_reg_idx  <= 5'd0;
      r_byte_cnt <= 3'd0;
      r_snap     <= 32'h0000_0000;
      r_rd_addr  <= 5'd0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_reg_idx  <= w_nxt_reg_idx;
      r_byte_cnt <= w_nxt_byte_cnt;
      r_snap     <= w_nxt_snap;
      r_rd_addr  <= w_nxt_reg_idx;
      r_tx_data  <= w_nxt_tx_data;
      r_tx_valid <= (w_nxt_state == ST_SEND);
      r_busy     <= (w_nxt_state != ST_IDLE);
      r_done     <= (w_nxt_state == ST_DONE);
    end
  end

  assign bus.rd_addr  = r_rd_addr;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_regfile_dump.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump
// Three sequencers share one behavioural register file:
//   u_one   : range 1..1, tagged   (cycle table incl. backpressure, start
//             while busy / in DONE)
//   u_full  : range 0..31, tagged  (full dump, snapshot rule, reset mid-dump)
//   u_notag : range 5..5, untagged
// -----------------------------------------------------------------------------
module tb_regfile_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_one, start_full, start_notag;
  logic busy_one, done_one, busy_full, done_full, busy_notag, done_notag;
  logic [31:0] regs [32];

  regfile_dump_if if_one ();
  regfile_dump_if if_full ();
  regfile_dump_if if_notag ();

  assign if_one.rd_data   = regs[if_one.rd_addr];
  assign if_full.rd_data  = regs[if_full.rd_addr];
  assign if_notag.rd_data = regs[if_notag.rd_addr];

  regfile_dump #(.FIRST_REG(1), .LAST_REG(1), .TAG_EN(1)) u_one (
    .i_clk(clk), .i_rst(rst), .i_start(start_one), .bus(if_one),
    .o_busy(busy_one), .o_done(done_one));

  regfile_dump u_full (
    .i_clk(clk), .i_rst(rst), .i_start(start_full), .bus(if_full),
    .o_busy(busy_full), .o_done(done_full));

  regfile_dump #(.FIRST_REG(5), .LAST_REG(5), .TAG_EN(0)) u_notag (
    .i_clk(clk), .i_rst(rst), .i_start(start_notag), .bus(if_notag),
    .o_busy(busy_notag), .o_done(done_notag));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle vector: inputs driven after the check, outputs expected now.
  typedef struct {
    logic       start;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t tbl [14];

  logic [7:0] full_q [$];
  int last_hs_cyc;
  int done_cyc;

  task automatic init_regs();
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101;
  endtask

  // Runs one u_full dump with tx_ready=1; optionally writes r2/r3 mid-SEND of r2.
  task automatic run_full(input bit with_write);
    int cyc;
    full_q.delete();
    last_hs_cyc = 0;
    done_cyc    = 0;
    cyc         = 0;
    @(negedge clk);
    start_full = 1'b1;
    while (cyc < 400 && done_cyc == 0) begin
      @(negedge clk);
      cyc++;
      start_full = 1'b0;
      if (if_full.tx_valid && if_full.tx_ready) begin
        full_q.push_back(if_full.tx_data);
        last_hs_cyc = cyc;
      end
      if (done_full) done_cyc = cyc;
      if (with_write && cyc == 15) begin
        regs[2] = 32'h0000_0000;
        regs[3] = 32'hDEAD_BEEF;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q_notag [$];
    logic [7:0] snap_exp [10];
    logic [31:0] got;
    int bad;
    int dcount;

    //            start  ready  valid data   busy  done
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h34, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h34, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h34, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h56, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h78, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h78, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    // Reset
    init_regs();
    rst = 1'b1;
    start_one = 1'b0; start_full = 1'b0; start_notag = 1'b0;
    if_one.tx_ready = 1'b0; if_full.tx_ready = 1'b1; if_notag.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rd_addr",  32'(if_full.rd_addr),  32'h0);
    check("rst_tx_data",  32'(if_full.tx_data),  32'h0);
    check("rst_tx_valid", 32'(if_full.tx_valid), 32'h0);
    check("rst_busy",     32'(busy_full),        32'h0);
    check("rst_done",     32'(done_full),        32'h0);
    rst = 1'b0;

    // Single register with backpressure, start during SEND and DONE
    regs[1] = 32'h1234_5678;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check($sformatf("one_valid[%0d]", i), 32'(if_one.tx_valid), 32'(tbl[i].exp_valid));
      check($sformatf("one_data[%0d]", i),  32'(if_one.tx_data),  32'(tbl[i].exp_data));
      check($sformatf("one_busy[%0d]", i),  32'(busy_one),        32'(tbl[i].exp_busy));
      check($sformatf("one_done[%0d]", i),  32'(done_one),        32'(tbl[i].exp_done));
      start_one       = tbl[i].start;
      if_one.tx_ready = tbl[i].ready;
    end
    start_one = 1'b0;

    // Untagged single register
    regs[5] = 32'h00FF_00FF;
    dcount  = 0;
    @(negedge clk);
    start_notag = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start_notag = 1'b0;
      if (if_notag.tx_valid && if_notag.tx_ready) q_notag.push_back(if_notag.tx_data);
      if (done_notag) dcount++;
    end
    check("notag_count", 32'(q_notag.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      got = (i < q_notag.size()) ? 32'(q_notag[i]) : 32'hFFFF_FFFF;
      check($sformatf("notag_byte[%0d]", i), got, (i % 2 == 0) ? 32'h00 : 32'hFF);
    end
    check("notag_done_pulses", 32'(dcount), 32'd1);

    // Full dump 0..31
    init_regs();
    run_full(1'b0);
    check("full_count", 32'(full_q.size()), 32'd160);
    bad = 0;
    for (int j = 0; j < full_q.size(); j++) begin
      // Tag and every data byte of register r both equal r for this pattern.
      if (full_q[j] !== 8'(j / 5)) bad++;
    end
    check("full_bad_bytes", 32'(bad), 32'd0);
    for (int j = 155; j < 160; j++) begin
      got = (j < full_q.size()) ? 32'(full_q[j]) : 32'hFFFF_FFFF;
      check($sformatf("full_r31_byte[%0d]", j - 155), got, 32'h1F);
    end
    check("full_last_hs_cycle", 32'(last_hs_cyc), 32'd192);
    check("full_done_cycle",    32'(done_cyc),    32'd193);
    @(negedge clk);
    check("full_busy_after", 32'(busy_full), 32'h0);
    check("full_done_after", 32'(done_full), 32'h0);

    // Snapshot rule: r2 written after its LOAD, r3 before its LOAD
    init_regs();
    regs[2] = 32'hAAAA_5555;
    regs[3] = 32'h3333_3333;
    snap_exp = '{8'h02, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_full(1'b1);
    for (int j = 0; j < 10; j++) begin
      got = (j + 10 < full_q.size()) ? 32'(full_q[j + 10]) : 32'hFFFF_FFFF;
      check($sformatf("snap_byte[%0d]", j), got, 32'(snap_exp[j]));
    end

    // Reset during SEND of the third register (r2)
    init_regs();
    regs[0] = 32'hC0FF_EE00;
    @(negedge clk);
    start_full = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start_full = 1'b0;
    end
    check("mid_in_send", 32'(if_full.tx_valid), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid",   32'(if_full.tx_valid), 32'h0);
    check("mid_rst_busy",    32'(busy_full),        32'h0);
    check("mid_rst_done",    32'(done_full),        32'h0);
    check("mid_rst_rd_addr", 32'(if_full.rd_addr),  32'h0);
    dcount = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_full || busy_full) dcount++;
    end
    check("mid_rst_quiet", 32'(dcount), 32'd0);

    // rst and start together: rst wins
    rst = 1'b1;
    start_full = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_full = 1'b0;
    check("rst_start_busy", 32'(busy_full), 32'h0);
    @(negedge clk);
    check("rst_start_busy2", 32'(busy_full), 32'h0);

    // Restart after abandoned dump begins again at register 0
    run_full(1'b0);
    check("restart_count", 32'(full_q.size()), 32'd160);
    got = (full_q.size() > 1) ? {16'h0, full_q[0], full_q[1]} : 32'hFFFF_FFFF;
    check("restart_first_bytes", got, 32'h0000_00C0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
